// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: enumerates all W-bit patterns with exactly K ones in ascending order over a valid/ready stream.
// Optional popcount self-check enabled by defining ONES_GEN_SELFCHECK_EN.
module ones_pattern_gen #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic [15:0]   out_index,
    output logic          done,
    output logic          err,
    output logic          chk_err
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [W-1:0] ones = '1;
    state_t state;
    logic [CW-1:0] k;
    logic [CW-1:0] tz;
    logic [W-1:0] lsb, sum, nxt, top, low_start;
    // Gosper's hack with the divide by the lowest set bit replaced by a shift by its position.
    always_comb begin
        tz = '0;
        for (int i = W - 1; i >= 0; i--)
            if (out_data[i]) tz = CW'(i);
        lsb = out_data & (-out_data);
        sum = out_data + lsb;
        nxt = sum | (((sum ^ out_data) >> 2) >> tz);
        top = ones << (W - int'(k));
        low_start = ones >> (W - int'(count));
    end
    assign busy = (state == RUN);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_index <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (int'(count) > W) begin
                        err <= 1'b1;
                    end else begin
                        state     <= RUN;
                        k         <= count;
                        out_valid <= 1'b1;
                        out_data  <= low_start;
                        out_last  <= (count == '0) || (int'(count) == W);
                        out_index <= '0;
                    end
                end
                RUN: if (out_ready) begin
                    if (out_last) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        out_data  <= nxt;
                        out_last  <= (nxt == top);
                        out_index <= out_index + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ONES_GEN_SELFCHECK_EN
    logic [CW-1:0] pop;
    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++)
            pop = pop + CW'(out_data[i]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chk_err <= 1'b0;
        else if (out_valid && pop != k) chk_err <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: scoreboard bench for ones_pattern_gen (W=8); expected patterns come from a brute-force popcount scan.
module tb_ones_pattern_gen;
    logic clk = 1'b0;
    logic rst, start, out_ready;
    logic [3:0] count;
    logic busy, out_valid, out_last, done, err, chk_err;
    logic [7:0] out_data;
    logic [15:0] out_index;
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    ones_pattern_gen #(.W(8), .CW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_index(out_index), .done(done), .err(err),
        .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    task automatic fill_model(input int k);
        exp_q.delete();
        for (int v = 0; v < 256; v++)
            if ($countones(8'(v)) == k) exp_q.push_back(8'(v));
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; count = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, out_valid, out_data, out_last, out_index, done, err, chk_err} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b data=%h last=%b idx=%0d done=%b err=%b chk=%b, want all 0",
                     busy, out_valid, out_data, out_last, out_index, done, err, chk_err);
        end
        rst = 1'b0;
    endtask

    task automatic run_enum(input int k, input bit rnd, input bit pre_started, input bit chain, input int nk);
        int idx = 0;
        int cyc = 0;
        fill_model(k);
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1; count = 4'(k);
        end
        @(negedge clk);
        start = 1'b0;
        while (exp_q.size() > 0 && cyc < 5000) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL k%0d_flags idx %0d: valid=%b busy=%b done=%b, want 1 1 0", k, idx, out_valid, busy, done);
            end
            checks++;
            if (out_data !== exp_q[0] || out_index !== 16'(idx) || out_last !== (exp_q.size() == 1)) begin
                errors++;
                $display("FAIL k%0d_pattern idx %0d: data=%h index=%0d last=%b, want data=%h index=%0d last=%b",
                         k, idx, out_data, out_index, out_last, exp_q[0], idx, exp_q.size() == 1);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            count = 4'($urandom_range(0, 15));
            if (out_ready) begin
                void'(exp_q.pop_front());
                idx++;
                if (exp_q.size() == 0) begin
                    start = chain;
                    count = 4'(nk);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL k%0d_timeout: %0d patterns still outstanding, want 0", k, exp_q.size());
            return;
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL k%0d_done: done=%b valid=%b busy=%b, want 1 0 0", k, done, out_valid, busy);
        end
        if (!chain) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL k%0d_done_pulse: done=%b valid=%b, want 0 0", k, done, out_valid);
            end
        end
    endtask

    task automatic test_err(input int k);
        @(negedge clk);
        start = 1'b1; count = 4'(k);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_k%0d: err=%b valid=%b busy=%b, want 1 0 0", k, err, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_k%0d: err=%b valid=%b busy=%b, want 0 0 0", k, err, out_valid, busy);
        end
    endtask

    task automatic test_midreset();
        fill_model(3);
        @(negedge clk);
        start = 1'b1; count = 4'd3;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (out_data !== exp_q[0] || out_index !== 16'(n)) begin
                errors++;
                $display("FAIL midreset_pattern %0d: data=%h index=%0d, want %h %0d", n, out_data, out_index, exp_q[0], n);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, out_valid, out_data, out_last, out_index, done, err, chk_err} !== 30'd0) begin
            errors++;
            $display("FAIL midreset_async: busy=%b valid=%b data=%h last=%b idx=%0d done=%b, want all 0",
                     busy, out_valid, out_data, out_last, out_index, done);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b1; count = 4'd3;
        run_enum(3, 1'b0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        run_enum(2, 1'b0, 1'b0, 1'b0, 0);
        run_enum(0, 1'b0, 1'b0, 1'b0, 0);
        run_enum(8, 1'b0, 1'b0, 1'b0, 0);
        test_err(9);
        test_err(15);
        run_enum(4, 1'b1, 1'b0, 1'b0, 0);
        run_enum(1, 1'b0, 1'b0, 1'b1, 7);
        run_enum(7, 1'b1, 1'b1, 1'b0, 0);
        test_midreset();
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_err_final: got %b, want 0", chk_err);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ones_pattern_gen.md
ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

Interface
REQ-001 Parameter W, default 8, pattern width in bits; legal range 2..16.
REQ-002 Parameter CW, default 4, count width; SHALL equal clog2(W+1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a new enumeration; sampled only in IDLE.
REQ-006 count  input  CW  required number of ones K, sampled with start.
REQ-007 busy  output  1  high in RUN state.
REQ-008 out_valid  output  1  out_data holds a valid pattern.
REQ-009 out_ready  input  1  consumer accepts pattern when out_valid & out_ready.
REQ-010 out_data  output  W  pattern with exactly K ones.
REQ-011 out_last  output  1  out_data is final pattern of the enumeration.
REQ-012 out_index  output  16  zero-based ordinal of current pattern.
REQ-013 done  output  1  one-cycle pulse after final pattern accepted.
REQ-014 err  output  1  one-cycle pulse when start rejected for K > W.
REQ-015 chk_err  output  1  sticky self-check failure flag (see Configuration).

Function
REQ-016 States IDLE and RUN only; reset state IDLE.
REQ-017 IDLE & start & K<=W: next cycle RUN, out_data = lowest K bits set (value 2^K-1), out_index=0, out_valid=1.
REQ-018 IDLE & start & K>W: stay IDLE, err=1 for exactly one cycle, no pattern emitted.
REQ-019 start in RUN ignored; count changes in RUN ignored (K latched at acceptance).
REQ-020 out_data, out_last, out_index held stable while out_valid & !out_ready.
REQ-021 Handshake with out_last=0: next cycle out_data = next larger W-bit value with same popcount K, out_index+1; no bubble cycle.
REQ-022 out_last=1 exactly when out_data = K ones in MSBs (top K bits set, others 0).
REQ-023 Handshake with out_last=1: next cycle IDLE, out_valid=0, done=1 for one cycle.
REQ-024 K=0: single pattern 0 with out_last=1; K=W: single pattern all-ones with out_last=1.
REQ-025 Patterns emitted in strictly ascending unsigned order; total count = C(W,K).
REQ-026 start in the done cycle accepted (IDLE already reached); done and new out_valid never overlap.
REQ-027 No combinational path from out_ready to out_valid or out_data.
REQ-028 Next-pattern logic single-cycle; no division operators required beyond what synthesizes for W<=16.

Reset
REQ-029 rst asserted: immediately IDLE, busy=0, out_valid=0, out_data=0, out_last=0, out_index=0, done=0, err=0, chk_err=0.
REQ-030 rst mid-enumeration abandons it; first post-reset start restarts from 2^K-1.
REQ-031 Deassertion of rst needs no handshake; start in first cycle after release accepted.

Configuration
REQ-032 Macro ONES_GEN_SELFCHECK_EN defined: internal popcount of out_data compared with latched K on every cycle out_valid=1; mismatch sets chk_err, cleared only by rst.
REQ-033 Macro undefined: no popcount logic instantiated, chk_err tied 0; all other behaviour identical.

Verification
REQ-034 W=8, start K=2, out_ready=1 always -> 28 patterns 0x03,0x05,0x06,0x09,... 0xC0; out_last on 0xC0, out_index 27, done one cycle later.
REQ-035 K=0 -> single 0x00 with out_last=1; K=8 -> single 0xFF with out_last=1; each followed by done pulse.
REQ-036 K=9 with W=8 -> err pulse one cycle, out_valid stays 0, busy stays 0.
REQ-037 K=4, out_ready toggled randomly -> 70 patterns, ascending, each popcount 4, held stable across stalls, chk_err stays 0.
REQ-038 K=3, rst asserted after 10th handshake -> outputs zero same cycle; restart K=3 yields 0x07 index 0.
